// File: rtl/display_pkg.sv
`default_nettype none
// +-----------------------------------------------------------------------+
// | display_pkg                                                            |
// | Pixel packing and address-width helpers shared with the PWM driver.    |
// | Rev 1.0                                                                |
// +-----------------------------------------------------------------------+
package display_pkg;

  localparam int NUM_CHANNELS = 3;
  localparam int R_CH         = 0;
  localparam int G_CH         = 1;
  localparam int B_CH         = 2;

  // Bit offset of a colour channel inside a {B,G,R} pixel word.
  function automatic int chan_lsb(input int ch, input int bw);
    return ch * bw;
  endfunction

  function automatic int addr_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage
`default_nettype wire

// File: rtl/display_framebuffer_bank.sv
`default_nettype none
// +-----------------------------------------------------------------------+
// | display_framebuffer_bank                                               |
// | Simple dual-port RAM: one write port, one registered read port.        |
// | Rev 1.0                                                                |
// +-----------------------------------------------------------------------+
module display_framebuffer_bank #(
  parameter int DATA_W = 24,
  parameter int DEPTH  = 512,
  parameter int ADDR_W = 9
) (
  input  logic              clk,
  input  logic              we,
  input  logic [ADDR_W-1:0] waddr,
  input  logic [DATA_W-1:0] wdata,
  input  logic [ADDR_W-1:0] raddr,
  output logic [DATA_W-1:0] rdata
);

  logic [DATA_W-1:0] mem_q [DEPTH];
  logic [DATA_W-1:0] rdata_q;

  // Contents are deliberately not reset; the top masks reads until valid.
  always_ff @(posedge clk) begin
    if (we) begin
      mem_q[waddr] <= wdata;
    end
    rdata_q <= mem_q[raddr];
  end

  assign rdata = rdata_q;

endmodule
`default_nettype wire

// File: rtl/display_framebuffer.sv
`default_nettype none
// +-----------------------------------------------------------------------+
// | display_framebuffer                                                    |
// | Double-buffered frame store; swaps banks on the driver frame_complete. |
// | Rev 1.0                                                                |
// +-----------------------------------------------------------------------+
module display_framebuffer
  import display_pkg::*;
#(
  parameter int SEGMENTS = 1,
  parameter int ROWS     = 8,
  parameter int COLUMNS  = 32,
  parameter int BITWIDTH = 8
) (
  input  logic                                      clk,
  input  logic                                      rst,
  input  logic                                      in_valid,
  output logic                                      in_ready,
  input  logic                                      in_sof,
  input  logic [NUM_CHANNELS*BITWIDTH-1:0]          in_data,
  input  logic                                      frame_complete,
  input  logic [addr_w(ROWS)-1:0]                   row,
  input  logic [addr_w(COLUMNS)-1:0]                column,
  output logic [NUM_CHANNELS*BITWIDTH*SEGMENTS-1:0] pixel,
  output logic                                      swapped,
  output logic                                      frame_pending,
  output logic                                      sync_error
);

  localparam int PIX_W   = NUM_CHANNELS * BITWIDTH;
  localparam int PER_SEG = ROWS * COLUMNS;
  localparam int DEPTH   = SEGMENTS * PER_SEG;
  localparam int WIDX_W  = addr_w(DEPTH + 1);
  localparam int LOCAL_W = addr_w(PER_SEG);

  localparam logic [WIDX_W-1:0] LAST_IDX  = WIDX_W'(DEPTH - 1);
  localparam logic [WIDX_W-1:0] PER_SEG_W = WIDX_W'(PER_SEG);

  localparam logic [0:0] ST_FILL    = 1'b0;
  localparam logic [0:0] ST_PENDING = 1'b1;

  logic [0:0]        state_q, state_d;
  logic [WIDX_W-1:0] widx_q, widx_d;
  logic              front_sel_q, front_sel_d;
  logic              front_valid_q, front_valid_d;
  logic              rd_valid_q, rd_valid_d;
  logic              swapped_q, swapped_d;
  logic              sync_error_q, sync_error_d;

  logic              accept;
  logic [WIDX_W-1:0] wr_idx;
  logic [WIDX_W-1:0] wr_seg;
  logic [LOCAL_W-1:0] wr_local;
  logic [LOCAL_W-1:0] rd_local;

  assign accept   = in_valid && (state_q == ST_FILL);
  assign wr_idx   = in_sof ? '0 : widx_q;
  assign wr_seg   = wr_idx / PER_SEG_W;
  assign wr_local = LOCAL_W'(wr_idx % PER_SEG_W);
  assign rd_local = LOCAL_W'(row) * LOCAL_W'(COLUMNS) + LOCAL_W'(column);

  always_comb begin
    state_d       = state_q;
    widx_d        = widx_q;
    front_sel_d   = front_sel_q;
    front_valid_d = front_valid_q;
    swapped_d     = 1'b0;
    sync_error_d  = sync_error_q;
    rd_valid_d    = front_valid_q;
    case (state_q)
      ST_FILL: begin
        // frame_complete is ignored here, even when the last beat lands alongside it.
        if (accept) begin
          if (in_sof) begin
            if (widx_q != '0) begin
              sync_error_d = 1'b1;
            end
            widx_d = WIDX_W'(1);
          end else if (widx_q == LAST_IDX) begin
            widx_d  = '0;
            state_d = ST_PENDING;
          end else begin
            widx_d = widx_q + WIDX_W'(1);
          end
        end
      end
      default: begin
        if (frame_complete) begin
          state_d       = ST_FILL;
          front_sel_d   = ~front_sel_q;
          front_valid_d = 1'b1;
          swapped_d     = 1'b1;
        end
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q       <= ST_FILL;
      widx_q        <= '0;
      front_sel_q   <= 1'b0;
      front_valid_q <= 1'b0;
      rd_valid_q    <= 1'b0;
      swapped_q     <= 1'b0;
      sync_error_q  <= 1'b0;
    end else begin
      state_q       <= state_d;
      widx_q        <= widx_d;
      front_sel_q   <= front_sel_d;
      front_valid_q <= front_valid_d;
      rd_valid_q    <= rd_valid_d;
      swapped_q     <= swapped_d;
      sync_error_q  <= sync_error_d;
    end
  end

  generate
    for (genvar s = 0; s < SEGMENTS; s++) begin : g_seg
      logic [PIX_W-1:0] rdata;

      display_framebuffer_bank #(
        .DATA_W(PIX_W),
        .DEPTH (2 * PER_SEG),
        .ADDR_W(LOCAL_W + 1)
      ) u_bank (
        .clk  (clk),
        .we   (accept && (wr_seg == WIDX_W'(s))),
        .waddr({~front_sel_q, wr_local}),
        .wdata(in_data),
        .raddr({front_sel_q, rd_local}),
        .rdata(rdata)
      );

      // The validity flag is delayed with the read so the first swap never exposes stale RAM.
      assign pixel[PIX_W*s +: PIX_W] = rd_valid_q ? rdata : '0;
    end
  endgenerate

  assign in_ready      = (state_q == ST_FILL);
  assign frame_pending = (state_q == ST_PENDING);
  assign swapped       = swapped_q;
  assign sync_error    = sync_error_q;

endmodule
`default_nettype wire

// File: doc/display_framebuffer.md
# display_framebuffer

Double-buffered pixel frame store that sits directly upstream of the PWM display driver. A host-side pixel stream fills the back buffer. The driver's row/column address reads the front buffer with one cycle of latency, which matches the driver's `load_delay = 1`. Buffers swap only on the driver's `frame_complete`, so a partially written frame is never displayed.

## Interface
- `segments`, 1: independently scanned display segments; all are read in parallel.
- `rows`, 8: addressable rows per segment.
- `columns`, 32: pixels per row.
- `bitwidth`, 8: bits per colour channel.

- `clk` in 1: sole clock, rising edge.
- `rst` in 1: asynchronous, active-low reset.
- `in_valid` in 1: host pixel beat valid.
- `in_ready` out 1: beat accepted when `in_valid && in_ready`.
- `in_sof` in 1: start of frame, qualified by an accepted beat.
- `in_data` in `3*bitwidth`: pixel as {B,G,R}, with R at bits `[bitwidth-1:0]`.
- `frame_complete` in 1: one-cycle pulse from the driver at the end of a scanned frame.
- `row` in `$clog2(rows)`: read row address.
- `column` in `$clog2(columns)`: read column address.
- `pixel` out `3*bitwidth*segments`: segment s occupies `[3*bitwidth*s +: 3*bitwidth]`.
- `swapped` out 1: one-cycle pulse in the cycle after a buffer swap.
- `frame_pending` out 1: back buffer is full and waiting for a swap.
- `sync_error` out 1: sticky; set when `in_sof` arrives mid-frame.

## Operation
- Storage is two banks, each holding `segments*rows*columns` pixels.
- `front_sel` selects the bank that is read; the write side always targets `!front_sel`.
- Write index `widx` runs over 0 .. `segments*rows*columns-1` in row-major order:
  - segment = `widx / (rows*columns)`
  - row = `(widx / columns) % rows`
  - column = `widx % columns`
- Accepted beat with `in_sof=1`:
  - The beat is written to index 0 and `widx` becomes 1.
  - If `widx` was not 0 beforehand, `sync_error` is set and the partial frame is discarded.
- Accepted beat at the last index:
  - `widx` wraps to 0.
  - `frame_pending` goes to 1.
  - `in_ready` goes to 0 from the next cycle.
- While `frame_pending=1`, `in_ready=0`; no beats are accepted.
- `frame_complete=1` while `frame_pending=1`:
  - `front_sel` toggles, `frame_pending` clears, `in_ready` returns to 1.
  - `front_valid` goes to 1; `swapped` pulses the following cycle.
- `frame_complete` while `frame_pending=0` is ignored.
- Read side: each segment's bank is read at (`row`, `column`) and registered into `pixel`.
- `pixel` is forced to 0 while `front_valid=0`, i.e. until the first swap after reset. Memory contents are not reset.
- Write-side state machine:
  - FILL: `in_ready=1`; accepting beats.
  - PENDING: `in_ready=0`; waiting for `frame_complete`.
  - FILL → PENDING on the last beat.
  - PENDING → FILL on `frame_complete`.

## Timing
- Reset values: `in_ready=1`, `pixel=0`, `swapped=0`, `frame_pending=0`, `sync_error=0`. Internally `front_sel=0`, `front_valid=0`, `widx=0`, state FILL.
- Read latency is exactly 1 cycle: an address presented at edge N appears on `pixel` after edge N+1.
- A swap is visible to reads from the cycle after the `frame_complete` cycle. A read issued in the `frame_complete` cycle returns old-bank data.
- Last beat accepted in the same cycle as `frame_complete`: `frame_pending` sets, no swap occurs, and the swap waits for the next `frame_complete`.
- `in_sof` on the last-index beat: treated as a restart at index 0, not as frame completion.
- Reset mid-fill: `widx` is cleared and any partial frame is lost. `front_valid` is cleared, so `pixel` reads 0.
- Write and read never touch the same bank, so there is no read-during-write hazard.

## Structure
- Shared package `display_pkg` holds:
  - Pixel channel packing offsets (R/G/B slice positions).
  - Address-width helpers (`$clog2` of rows, columns, depth) shared with the driver.
- Sub-module `display_framebuffer_bank`: simple dual-port RAM, one write port and one registered read port.
  - Depth is `2*rows*columns`; the address MSB is the bank select.
  - Instantiate one per segment.

## Test plan
- After reset with any `row`/`column`: `pixel==0`, `in_ready==1`, `frame_pending==0`.
- Stream 256 beats (segments=1) with `in_data=index`, `in_sof` on beat 0, then pulse `frame_complete`:
  - `swapped` pulses one cycle later.
  - Reading row 3, column 5 returns 101 one cycle after the address.
- Fill a frame with no `frame_complete`: `in_ready` stays 0 for 1000 cycles and no beats are accepted. Pulse `frame_complete`: `in_ready` returns to 1 the next cycle.
- Last beat accepted in the same cycle as a `frame_complete` pulse: no swap and `pixel` is unchanged. The next `frame_complete` swaps.
- `in_sof` at beat 40:
  - `sync_error` goes to 1.
  - After a full frame from index 0 and a swap, the data at row 0, column 0 equals the sof beat's value.
- segments=2, `in_data=index`: after a swap, `pixel` at row 0, column 0 is {256, 0}.
- Drive `rst` low mid-frame: `pixel` reads 0 and the subsequent refill and swap display correctly.
